// File: rtl/dsa_mem_arbiter.sv
// Image-memory arbiter: host, write port and SIMD read lanes onto one port.
// Optional grant statistics are built when DSA_MEM_ARB_STATS_EN is defined.
module dsa_mem_arbiter #(
  parameter int N_LANES  = 4,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_gnt,
  output logic                        host_rvalid,
  output logic [DATA_W-1:0]           host_rdata,
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_gnt,
  input  logic [N_LANES-1:0]          lane_req,
  input  logic [N_LANES*ADDR_W-1:0]   lane_addr,
  output logic [N_LANES-1:0]          lane_gnt,
  output logic [N_LANES-1:0]          lane_rvalid,
  output logic [DATA_W-1:0]           lane_rdata,
  input  logic                        step_en,
  input  logic                        step_pulse,
  output logic                        mem_we,
  output logic                        mem_re,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [31:0]                 stat_host,
  output logic [31:0]                 stat_wr,
  output logic [31:0]                 stat_lane,
  output logic [31:0]                 stat_conflict
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef struct packed {
    logic          v;
    logic          host;
    logic [LW-1:0] lane;
  } tag_t;

  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] rr_idx;
  logic          rr_hit;
  logic [SW-1:0] starv_cnt;
  logic          credit;
  logic          step_ok;
  logic          starve;
  logic          lane_any;
  logic          rd_acc;
  tag_t          tag_n;
  tag_t          tag_q [RD_LAT+1];
  tag_t          tag_rt;

  // Round-robin search starting at rr_ptr
  always_comb begin
    int j;
    rr_hit = 1'b0;
    rr_idx = '0;
    j      = 0;
    for (int i = 0; i < N_LANES; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_LANES) j = j - N_LANES;
      if (!rr_hit && lane_req[j]) begin
        rr_hit = 1'b1;
        rr_idx = LW'(j);
      end
    end
  end

  assign step_ok = !step_en || credit;
  assign starve  = (starv_cnt == SW'(MAX_WAIT));

  always_comb begin
    host_gnt = 1'b0;
    wr_gnt   = 1'b0;
    lane_gnt = '0;
    if (!rst) begin
      priority case (1'b1)
        host_req: host_gnt = 1'b1;
        !step_ok: ;
        rr_hit && (starve || !wr_req): lane_gnt[rr_idx] = 1'b1;
        wr_req: wr_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign lane_any = |lane_gnt;
  assign rd_acc   = (host_gnt && !host_we) || lane_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      starv_cnt <= '0;
      credit    <= 1'b0;
    end else begin
      if (lane_any)
        rr_ptr <= (rr_idx == LW'(N_LANES - 1)) ? '0 : rr_idx + LW'(1);
      if (lane_any || !(|lane_req))
        starv_cnt <= '0;
      else if (wr_gnt && !starve)
        starv_cnt <= starv_cnt + SW'(1);
      if (!step_en || wr_gnt || lane_any)
        credit <= 1'b0;
      else if (step_pulse)
        credit <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= (host_gnt && host_we) || wr_gnt;
      if (host_gnt) begin
        mem_addr <= host_addr;
        if (host_we) mem_wdata <= host_wdata;
      end else if (wr_gnt) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (lane_any) begin
        mem_addr <= lane_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage 0 coincides with mem_re; the last stage meets the memory data
  assign tag_n = '{v: rd_acc, host: host_gnt, lane: rr_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_n;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign mem_re = tag_q[0].v;
  assign tag_rt = tag_q[RD_LAT];

  always_comb begin
    lane_rvalid = '0;
    for (int i = 0; i < N_LANES; i++)
      lane_rvalid[i] = tag_rt.v && !tag_rt.host && (tag_rt.lane == LW'(i));
  end

  assign host_rvalid = tag_rt.v && tag_rt.host;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign lane_rdata  = (|lane_rvalid) ? mem_rdata : '0;

`ifdef DSA_MEM_ARB_STATS_EN
  logic [1:0] n_pend;

  assign n_pend = 2'(host_req) + 2'(wr_req) + 2'(|lane_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_host     <= '0;
      stat_wr       <= '0;
      stat_lane     <= '0;
      stat_conflict <= '0;
    end else begin
      if (host_gnt) stat_host <= stat_host + 32'd1;
      if (wr_gnt)   stat_wr   <= stat_wr + 32'd1;
      if (lane_any) stat_lane <= stat_lane + 32'd1;
      if (n_pend >= 2'd2) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`else
  assign stat_host     = '0;
  assign stat_wr       = '0;
  assign stat_lane     = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_dsa_mem_arbiter.sv
// Directed bench for dsa_mem_arbiter with a fixed-latency ROM model.
// Stats expectations follow DSA_MEM_ARB_STATS_EN.
module tb_dsa_mem_arbiter;

  localparam int NL = 4;
  localparam int AW = 18;
  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic [NL-1:0] lane_req;
  logic [NL*AW-1:0] lane_addr;
  logic [NL-1:0] lane_gnt, lane_rvalid;
  logic [DW-1:0] lane_rdata;
  logic          step_en, step_pulse;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [31:0]   stat_host, stat_wr, stat_lane, stat_conflict;

  int n_chk = 0;
  int n_err = 0;
  int n_step;

  dsa_mem_arbiter #(
    .N_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .lane_req(lane_req), .lane_addr(lane_addr), .lane_gnt(lane_gnt),
    .lane_rvalid(lane_rvalid), .lane_rdata(lane_rdata),
    .step_en(step_en), .step_pulse(step_pulse),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_host(stat_host), .stat_wr(stat_wr), .stat_lane(stat_lane),
    .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory answers RL cycles after it sees mem_re
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem_re ? rom(mem_addr) : 8'h00;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    lane_req   = '0;
    step_en    = 1'b0;
    step_pulse = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, {host_gnt, wr_gnt, lane_gnt}, '0);
    chk({tag, "_mem"}, {mem_we, mem_re, mem_addr, mem_wdata}, '0);
    chk({tag, "_rv"}, {host_rvalid, lane_rvalid}, '0);
    chk({tag, "_st"}, {stat_host, stat_wr}, '0);
  endtask

  initial begin
    clear();
    lane_addr = {18'h103, 18'h102, 18'h101, 18'h100};
    rst = 1'b1;
    cyc(); cyc();
    #1 chk_quiet("reset");
    cyc();
    rst = 1'b0;
    cyc();

    // Host read beats all four lanes
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h123; lane_req = 4'hF;
    #1 chk("host_gnt", {host_gnt, wr_gnt, lane_gnt}, 6'b100000);
    cyc(); clear();
    #1 chk("host_mem", {mem_re, mem_we, mem_addr}, {2'b10, 18'h123});
    cyc();
    #1 chk("host_rv_early", host_rvalid, 1'b0);
    cyc();
    #1 chk("host_rv", {host_rvalid, host_rdata, lane_rvalid}, {1'b1, 8'h86, 4'h0});
    cyc();
    #1 chk("host_rv_end", host_rvalid, 1'b0);

    // Round-robin across all lanes, returns in order without bubbles
    for (int c = 0; c < 11; c++) begin
      cyc();
      lane_req = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) chk($sformatf("rr_gnt%0d", c), lane_gnt, 4'b1 << (c % 4));
      if (c >= 3)
        chk($sformatf("rr_rv%0d", c), {lane_rvalid, lane_rdata},
            {4'b1 << ((c - 3) % 4), rom(18'h100 + 18'((c - 3) % 4))});
      else
        chk($sformatf("rr_rv%0d", c), lane_rvalid, 4'h0);
    end

    // Write port starves lane 2 until the counter saturates
    for (int c = 0; c < 17; c++) begin
      cyc();
      wr_req = 1'b1; wr_addr = 18'h200; wr_data = 8'h55; lane_req = 4'b0100;
      #1;
      if (c == 15) chk("starve_lane", {wr_gnt, lane_gnt}, 5'b00100);
      else chk($sformatf("starve_wr%0d", c), {wr_gnt, lane_gnt}, 5'b10000);
      if (c == 1)
        chk("wr_mem", {mem_we, mem_re, mem_addr, mem_wdata},
            {2'b10, 18'h200, 8'h55});
      if (c == 16)
        chk("starve_mem", {mem_re, mem_addr}, {1'b1, 18'h102});
    end
    cyc(); clear();

    // Stepping: only pulses release write/lane grants; host ignores it
    n_step = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      step_en = 1'b1; wr_req = 1'b1; wr_addr = 18'h201; lane_req = 4'b0001;
      step_pulse = (c == 1 || c == 6);
      host_req = (c == 4); host_we = 1'b1; host_addr = 18'h300;
      #1;
      if (wr_gnt || lane_any()) n_step++;
      chk($sformatf("step%0d", c), {host_gnt, wr_gnt, lane_gnt},
          {c == 4, c == 2 || c == 7, 4'h0});
    end
    chk("step_count", 32'(n_step), 32'd2);
    cyc(); clear();

    // Reset discards in-flight lane reads and rewinds the pointer
    lane_req = 4'b0011;
    #1 chk("rst_g0", lane_gnt, 4'b0001);
    cyc();
    #1 chk("rst_g1", lane_gnt, 4'b0010);
    cyc();
    lane_req = '0; rst = 1'b1;
    #1 chk_quiet("rst_async");
    cyc();
    #1 chk_quiet("rst_hold");
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      #1 chk($sformatf("rst_norv%0d", c), {lane_rvalid, host_rvalid}, 5'b0);
    end
    cyc();
    lane_req = 4'hF;
    #1 chk("rst_ptr", lane_gnt, 4'b0001);
    cyc(); clear();

    // Statistics: 10 host, 5 write, 7 lane grants, one conflict cycle
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      clear();
      if (c < 10) begin
        host_req = 1'b1; host_addr = 18'(c);
      end
      if (c >= 9 && c < 15) begin
        wr_req = 1'b1; wr_addr = 18'(c);
      end
      if (c >= 15) lane_req = 4'hF;
      #1;
      if (c == 9) chk("st_conf_gnt", {host_gnt, wr_gnt}, 2'b10);
      if (c == 10) chk("st_wr_gnt", {host_gnt, wr_gnt}, 2'b01);
    end
    cyc(); clear();
    #1;
`ifdef DSA_MEM_ARB_STATS_EN
    chk("stat_host", stat_host, 32'd10);
    chk("stat_wr", stat_wr, 32'd5);
    chk("stat_lane", stat_lane, 32'd7);
    chk("stat_conflict", stat_conflict, 32'd1);
`else
    chk("stat_host", stat_host, 32'd0);
    chk("stat_wr", stat_wr, 32'd0);
    chk("stat_lane", stat_lane, 32'd0);
    chk("stat_conflict", stat_conflict, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  function automatic logic lane_any();
    return |lane_gnt;
  endfunction

endmodule

// File: doc/dsa_mem_arbiter.md
DSA_MEM_ARBITER -- requirements
Module: dsa_mem_arbiter

Interface
REQ-001 Parameter N_LANES, default 4: number of datapath read lanes (SIMD), 1..8.
REQ-002 Parameter ADDR_W, default 18: image-memory address width.
REQ-003 Parameter DATA_W, default 8: pixel width.
REQ-004 Parameter RD_LAT, default 2: fixed memory read latency in clk cycles, 1..4.
REQ-005 Parameter MAX_WAIT, default 15: maximum consecutive cycles a pending lane request may be denied by the write port.
REQ-006 clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 host_req / host_we  in  1/1  host (JTAG) access request and write qualifier; host_addr  in  ADDR_W; host_wdata  in  DATA_W.
REQ-008 host_gnt  out  1  host request accepted this cycle; host_rvalid  out  1  host read data valid; host_rdata  out  DATA_W.
REQ-009 wr_req  in  1  datapath result-write request; wr_addr  in  ADDR_W; wr_data  in  DATA_W; wr_gnt  out  1.
REQ-010 lane_req  in  N_LANES  per-lane read request; lane_addr  in  N_LANES*ADDR_W, lane i at [i*ADDR_W +: ADDR_W]; lane_gnt  out  N_LANES; lane_rvalid  out  N_LANES; lane_rdata  out  DATA_W (shared).
REQ-011 step_en  in  1  stepping mode; step_pulse  in  1  single-step trigger.
REQ-012 mem_we / mem_re  out  1/1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W.
REQ-013 stat_host, stat_wr, stat_lane, stat_conflict  out  32 each: statistics counters.

Function
REQ-014 At most one grant (host_gnt, wr_gnt, lane_gnt bits) shall be asserted per cycle; grants are combinational from the current requests and the registered arbiter state.
REQ-015 A request is accepted in the cycle where req and gnt are both high; requesters hold req/addr/data until then.
REQ-016 Priority: host > starvation-forced lane > write port > lanes in round-robin order.
REQ-017 Round-robin pointer rr_ptr (reset 0) searches lanes starting at rr_ptr; after lane k is granted, rr_ptr = (k+1) mod N_LANES; otherwise it is unchanged.
REQ-018 Starvation counter: increments when any lane_req is high and wr_gnt is asserted; saturates at MAX_WAIT; while at MAX_WAIT, the next eligible round-robin lane wins over the write port; clears on any lane grant or when no lane_req is high.
REQ-019 Stepping: when step_en=1, write and lane grants require a step credit; step_pulse sets the credit; a write or lane grant consumes it; pulse and grant in the same cycle leave the credit cleared; host grants ignore stepping; credit clears when step_en=0.
REQ-020 Accepted access drives mem_* registered one cycle later: mem_we=1 for a host write or the write port, mem_re=1 for a host read or a lane read; otherwise mem_we=mem_re=0 and mem_addr/mem_wdata hold.
REQ-021 Read return: a tag {valid, source} tracks each mem_re for RD_LAT cycles; exactly RD_LAT cycles after mem_re, the tagged source's rvalid pulses for one cycle, with host_rdata/lane_rdata = mem_rdata in that cycle.
REQ-022 Back-to-back reads shall be accepted every cycle; returns come in acceptance order with no bubbles.
REQ-023 rvalid outputs are 0 in cycles with no returning tag; rdata is don't-care then.

Reset
REQ-024 rst clears all outputs to 0, rr_ptr to 0, starvation counter, step credit, read tags, and statistics.
REQ-025 Reads in flight at reset are discarded; no rvalid is asserted after reset deassertion for them.

Configuration
REQ-026 With DSA_MEM_ARB_STATS_EN defined: stat_host/stat_wr/stat_lane count the respective grants, and stat_conflict counts cycles with two or more request classes pending; all wrap modulo 2^32.
REQ-027 Without DSA_MEM_ARB_STATS_EN: all stat_* outputs are constant 0 and no counter registers are instantiated.

Verification
REQ-028 host_req read plus lane_req=4'b1111 in the same cycle -> host_gnt only; host_rvalid 3 cycles later with mem_rdata (RD_LAT=2).
REQ-029 lane_req=4'b1111 held for 8 cycles -> lane_gnt sequence 0,1,2,3,0,1,2,3; lane_rvalid returns in the same order.
REQ-030 wr_req held and lane_req[2]=1 continuously -> lane 2 granted on the 16th cycle (MAX_WAIT=15), then wr_gnt resumes.
REQ-031 step_en=1, wr_req and lane_req pending, two step_pulse events 5 cycles apart -> exactly two grants, each in the cycle of or after a pulse; host granted without a pulse.
REQ-032 Two lane reads accepted, rst asserted the next cycle -> all outputs 0, no lane_rvalid after release, rr_ptr=0.
REQ-033 STATS_EN build: 10 host, 5 write and 7 lane grants -> stat_host=10, stat_wr=5, stat_lane=7; non-STATS build -> all stat_* remain 0.
